// File: rtl/pll_seq_pkg.sv
// Shared state encoding and sizing helpers for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } seq_state_e;

  // Width of a counter that must reach (largest of a, b, c) - 1; never below 1 bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses pll_rst, waits for a stable lock, then releases core_rst.
// state       | meaning
// ST_PLL_RST   | pll_rst held for RST_CYCLES
// ST_WAIT_LOCK | waiting for synchronized lock, bounded by LOCK_TIMEOUT
// ST_SETTLE    | lock must hold for STABLE_CYCLES consecutive cycles
// ST_RUN       | locked and stable, core released
// ST_FAIL      | retries exhausted, waits for relock_req
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 32,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       ready,
  output logic       fail,
  output logic [1:0] retry_cnt,
  output logic [2:0] state
);

  localparam int unsigned CNT_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRY);

  logic             locked_s;
  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic             pll_rst_q, core_rst_q, ready_q, fail_q;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    if (relock_req) begin
      state_d = ST_PLL_RST;
      if (state_q == ST_FAIL) retry_d = '0;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          cnt_d = cnt_q + 1'b1;
          if (locked_s) begin
            state_d = ST_SETTLE;
          end else if (cnt_q == LOCK_LAST) begin
            if (retry_q >= RETRY_MAX) begin
              state_d = ST_FAIL;
            end else begin
              retry_d = retry_q + 2'd1;
              state_d = ST_PLL_RST;
            end
          end
        end
        ST_SETTLE: begin
          cnt_d = cnt_q + 1'b1;
          if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            retry_d = '0;
          end
        end
        ST_RUN:  if (!locked_s) state_d = ST_PLL_RST;
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_PLL_RST;
      endcase
    end
    // Every entry into a state, including a relock_req restart, starts the count from zero.
    if (relock_req || (state_d != state_q)) cnt_d = '0;
  end

  // Outputs decode state_d so they change on the same edge as the state itself.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_PLL_RST;
      cnt_q      <= '0;
      retry_q    <= '0;
      pll_rst_q  <= 1'b1;
      core_rst_q <= 1'b1;
      ready_q    <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      pll_rst_q  <= (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
      core_rst_q <= (state_d != ST_RUN);
      ready_q    <= (state_d == ST_RUN);
      fail_q     <= (state_d == ST_FAIL);
    end
  end

  assign pll_rst   = pll_rst_q;
  assign core_rst  = core_rst_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule
